vector_sequencer: RTL
=====================

Name: vector_sequencer

Overview:
Parametrised successor to the single-channel vector control block. Accepts jump/draw commands on a valid/ready interface, generates Bresenham line points internally, and emits a point stream (x, y, intensity) on a valid/ready interface to a downstream DAC serializer. Generalised over coordinate and intensity width. Dwell counts are programmable at runtime per command class instead of hard-coded.

Parameters:
COORD_W, 12, width of x/y coordinates (unsigned)
BRIGHT_W, 4, width of beam intensity
DWELL_W, 8, width of dwell count config inputs

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer accepts command this cycle
cmd_op  input  1  0 = jump, 1 = draw
cmd_x  input  COORD_W  target x
cmd_y  input  COORD_W  target y
cmd_bright  input  BRIGHT_W  draw intensity (ignored for jump)
cfg_jump_pre  input  DWELL_W  points held before jump
cfg_jump_post  input  DWELL_W  points held after jump
cfg_draw_pre  input  DWELL_W  points held before line
cfg_draw_post  input  DWELL_W  points held after line
out_valid  output  1  point valid
out_ready  input  1  downstream consumed point
out_x  output  COORD_W  point x
out_y  output  COORD_W  point y
out_bright  output  BRIGHT_W  beam intensity for point; 0 = blanked
busy  output  1  state != IDLE

Behaviour:
- Reset (async, reset_n low): state IDLE; current position (0,0); out_valid 0; out_x/out_y/out_bright 0; cmd_ready 1; busy 0. Reset mid-command abandons it; no partial points follow.
- cmd_ready = (state == IDLE) && !(out_valid && !out_ready). Command accepted on cmd_valid && cmd_ready. cmd_op, target, bright and all four cfg values are latched at acceptance; later cfg changes do not affect the command in flight.
- Point handshake: out_* registered and held stable while out_valid && !out_ready. A point counts as emitted on out_valid && out_ready. After a handshake, the next point, if any, is presented the following cycle, giving 1 point/cycle at full throughput.
- States: IDLE, PRE, MOVE, LINE, POST.
- Jump: PRE emits cfg_jump_pre points at the old position with bright 0. MOVE emits 1 point at the target with bright 0, and the position updates. POST emits cfg_jump_post points at the target with bright 0. Then IDLE.
- Draw: PRE emits cfg_draw_pre points at the current position with bright = cmd_bright. LINE emits exactly max(|dx|,|dy|) points, one Bresenham step each, ending exactly on the target. POST emits cfg_draw_post points at the target with cmd_bright. Then IDLE, with position = target.
- A dwell count of 0 skips that state with no idle cycle. A zero-length draw emits only the PRE and POST points.
- Bresenham: dx, dy and err are signed, COORD_W+2 bits wide. sx, sy = ±1. err initialised to dx-dy. Per step: e2 = 2*err; if e2 > -dy then err -= dy and x += sx; if e2 < dx then err += dx and y += sy. All octants are supported, including dx=0 and dy=0. Coordinates never wrap: the endpoint is always within 0..2^COORD_W-1, and the line stays inside the box between start and target.
- A point is computed in the cycle it is handshaked. There is no combinational path from out_ready to out_x/out_y/out_bright.
- busy is high from the cycle after acceptance until the last point of POST is handshaked.

Optional Feature:
Macro VSEQ_IDLE_REFRESH_EN.
- Defined: in IDLE, out_valid stays 1 and repeats the current position with bright 0, keeping the DAC refreshed. cmd_ready is unchanged (a pending point stall still blocks acceptance). After reset, the first refresh point is (0,0) and is presented in the first cycle after reset_n deasserts.
- Undefined: out_valid is 0 in IDLE.

Test Plan:
- Reset, then jump to (100,200) with cfg_jump_pre=2, cfg_jump_post=3, out_ready=1 -> exactly 6 points: (0,0)x2, (100,200)x4, all bright 0; busy low afterwards; cmd_ready 1.
- From (0,0), draw to (5,2), bright 9, draw_pre=1, draw_post=1 -> points (0,0), (1,0), (2,1), (3,1), (4,2), (5,2), (5,2), all bright 9; LINE count 5.
- From (10,10), draw to (10,3) (vertical, negative), dwells 0 -> 7 points, y 9..3, x fixed at 10; then from (3,3) draw to (0,0) -> ends exactly on (0,0).
- Random out_ready backpressure during a draw (0,0)->(4095,4095) with all dwells 0 -> 4095 points; out_* stable during every stall; final point (4095,4095); no drops or duplicates.
- Assert reset_n low mid-LINE -> out_valid 0 and position (0,0) immediately (asynchronous); a new command after release starts from (0,0).
- With VSEQ_IDLE_REFRESH_EN defined, idle after a jump to (7,8) -> continuous (7,8) bright 0 points; a draw is accepted and its first PRE point follows; undefined -> out_valid 0 while idle.

Source files
------------

// File: rtl/vector_sequencer.sv
// vector_sequencer: jump/draw command sequencer emitting a Bresenham point stream.
// Optional macro VSEQ_IDLE_REFRESH_EN: while idle, repeat the current position blanked.
module vector_sequencer #(
    parameter int COORD_W  = 12,
    parameter int BRIGHT_W = 4,
    parameter int DWELL_W  = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [COORD_W-1:0]  cmd_x,
    input  logic [COORD_W-1:0]  cmd_y,
    input  logic [BRIGHT_W-1:0] cmd_bright,
    input  logic [DWELL_W-1:0]  cfg_jump_pre,
    input  logic [DWELL_W-1:0]  cfg_jump_post,
    input  logic [DWELL_W-1:0]  cfg_draw_pre,
    input  logic [DWELL_W-1:0]  cfg_draw_post,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COORD_W-1:0]  out_x,
    output logic [COORD_W-1:0]  out_y,
    output logic [BRIGHT_W-1:0] out_bright,
    output logic                busy
);

    localparam int SW = COORD_W + 2;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        MOVE,
        LINE,
        POST
    } state_t;

    state_t               state_q, state_d;
    logic                 op_q, op_d;
    logic [COORD_W-1:0]   tx_q, tx_d, ty_q, ty_d;
    logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic [BRIGHT_W-1:0]  br_q, br_d;
    logic [DWELL_W-1:0]   post_q, post_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic signed [SW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [SW-1:0] err_q, err_d;
    logic                 sx_q, sx_d, sy_q, sy_d;
    logic                 ov_q, ov_d;
    logic                 pc_q, pc_d;
    logic [COORD_W-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic [BRIGHT_W-1:0]  ob_q, ob_d;

    logic                 advance;
    logic signed [SW:0]   e2, dxe, dye;
    logic                 step_x, step_y;
    logic [COORD_W-1:0]   nx, ny;
    logic signed [SW-1:0] err_nx;
    logic [DWELL_W-1:0]   sel_pre, sel_post;
    logic                 acc_nz, run_nz;
    logic [COORD_W-1:0]   adx, ady;
    logic                 asx, asy;

    // First non-empty phase following 'done'; IDLE as 'done' means starting.
    function automatic state_t next_phase(
        input state_t             done,
        input logic               op,
        input logic [DWELL_W-1:0] pre,
        input logic [DWELL_W-1:0] post,
        input logic               nz
    );
        if (done == IDLE && pre != '0)
            return PRE;
        if (done == IDLE || done == PRE) begin
            if (!op)
                return MOVE;
            if (nz)
                return LINE;
        end
        if (done != POST && post != '0)
            return POST;
        return IDLE;
    endfunction

    assign out_valid  = ov_q;
    assign out_x      = ox_q;
    assign out_y      = oy_q;
    assign out_bright = ob_q;
    assign busy       = (state_q != IDLE) || (ov_q && pc_q);

    // Bresenham step from the current position, plus acceptance-time deltas.
    always_comb begin
        e2     = {err_q, 1'b0};
        dxe    = {dx_q[SW-1], dx_q};
        dye    = {dy_q[SW-1], dy_q};
        step_x = (e2 > -dye);
        step_y = (e2 < dxe);
        nx     = cx_q;
        ny     = cy_q;
        err_nx = err_q;
        if (step_x) begin
            nx     = sx_q ? cx_q - COORD_W'(1) : cx_q + COORD_W'(1);
            err_nx = err_nx - dy_q;
        end
        if (step_y) begin
            ny     = sy_q ? cy_q - COORD_W'(1) : cy_q + COORD_W'(1);
            err_nx = err_nx + dx_q;
        end
        sel_pre  = cmd_op ? cfg_draw_pre : cfg_jump_pre;
        sel_post = cmd_op ? cfg_draw_post : cfg_jump_post;
        acc_nz   = (cmd_x != cx_q) || (cmd_y != cy_q);
        run_nz   = (tx_q != cx_q) || (ty_q != cy_q);
        asx      = (cmd_x < cx_q);
        asy      = (cmd_y < cy_q);
        adx      = asx ? cx_q - cmd_x : cmd_x - cx_q;
        ady      = asy ? cy_q - cmd_y : cmd_y - cy_q;
    end

    // Next-state and next-point logic; a new point loads only when the slot frees.
    always_comb begin
        advance   = !ov_q || out_ready;
        cmd_ready = (state_q == IDLE) && advance;
        state_d   = state_q;
        op_d      = op_q;
        tx_d      = tx_q;
        ty_d      = ty_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        br_d      = br_q;
        post_d    = post_q;
        cnt_d     = cnt_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        err_d     = err_q;
        sx_d      = sx_q;
        sy_d      = sy_q;
        ov_d      = advance ? 1'b0 : ov_q;
        pc_d      = pc_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        ob_d      = ob_q;
        if (advance) begin
            case (state_q)
                IDLE: begin
`ifdef VSEQ_IDLE_REFRESH_EN
                    ov_d = 1'b1;
                    pc_d = 1'b0;
                    ox_d = cx_q;
                    oy_d = cy_q;
                    ob_d = '0;
`endif
                    if (cmd_valid) begin
                        op_d    = cmd_op;
                        tx_d    = cmd_x;
                        ty_d    = cmd_y;
                        br_d    = cmd_bright;
                        post_d  = sel_post;
                        sx_d    = asx;
                        sy_d    = asy;
                        dx_d    = SW'(adx);
                        dy_d    = SW'(ady);
                        err_d   = SW'(adx) - SW'(ady);
                        state_d = next_phase(IDLE, cmd_op,
                                             sel_pre, sel_post,
                                             acc_nz);
                        cnt_d   = (state_d == PRE) ? sel_pre
                                                   : sel_post;
                    end
                end
                PRE: begin
                    ov_d  = 1'b1;
                    pc_d  = 1'b1;
                    ox_d  = cx_q;
                    oy_d  = cy_q;
                    ob_d  = op_q ? br_q : '0;
                    cnt_d = cnt_q - DWELL_W'(1);
                    if (cnt_q == DWELL_W'(1)) begin
                        state_d = next_phase(PRE, op_q, '0,
                                             post_q, run_nz);
                        cnt_d   = post_q;
                    end
                end
                MOVE: begin
                    ov_d    = 1'b1;
                    pc_d    = 1'b1;
                    ox_d    = tx_q;
                    oy_d    = ty_q;
                    ob_d    = '0;
                    cx_d    = tx_q;
                    cy_d    = ty_q;
                    state_d = next_phase(MOVE, op_q, '0,
                                         post_q, 1'b0);
                    cnt_d   = post_q;
                end
                LINE: begin
                    ov_d  = 1'b1;
                    pc_d  = 1'b1;
                    ox_d  = nx;
                    oy_d  = ny;
                    ob_d  = br_q;
                    cx_d  = nx;
                    cy_d  = ny;
                    err_d = err_nx;
                    if (nx == tx_q && ny == ty_q) begin
                        state_d = next_phase(LINE, op_q, '0,
                                             post_q, 1'b0);
                        cnt_d   = post_q;
                    end
                end
                POST: begin
                    ov_d  = 1'b1;
                    pc_d  = 1'b1;
                    ox_d  = tx_q;
                    oy_d  = ty_q;
                    ob_d  = op_q ? br_q : '0;
                    cnt_d = cnt_q - DWELL_W'(1);
                    if (cnt_q == DWELL_W'(1))
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, position and output point registers; reset abandons any command.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            tx_q    <= '0;
            ty_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            br_q    <= '0;
            post_q  <= '0;
            cnt_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ov_q    <= 1'b0;
            pc_q    <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
            ob_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            br_q    <= br_d;
            post_q  <= post_d;
            cnt_q   <= cnt_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            ov_q    <= ov_d;
            pc_q    <= pc_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            ob_q    <= ob_d;
        end
    end

endmodule
